// File: rtl/prog_lut_if.sv
// prog_lut_if: loader write channel for the programmable branch-target table.
//   valid : loader presents an entry
//   ready : table accepts the entry this cycle
//   key   : branch-instruction address of the entry
//   val   : branch target of the entry
// master = loader side, slave = table side.
interface prog_lut_if #(
   parameter int ADDR_W = 9,
   parameter int VAL_W  = 16
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] key;
   logic [VAL_W-1:0]  val;

   modport master (output valid, key, val, input ready);
   modport slave  (input valid, key, val, output ready);
endinterface

// File: rtl/prog_lut.sv
// prog_lut: programmable branch-target table (key -> target) with a
// combinational lookup port for fetch and a one-entry-per-cycle clear sweep.
//
// State table
//   state | meaning
//   IDLE  | accepting loader writes; clear request starts a sweep
//   CLEAR | invalidating entry idx_q each cycle; no writes accepted
//
// Ports
//   clk           : clock, all state updates on rising edge
//   rst           : synchronous active-high reset
//   wr            : loader write channel (valid/ready/key/val)
//   clear_i       : request full-table sweep, sampled in IDLE only
//   lut_address_i : lookup key from fetch
//   lut_val_o     : matched target, 0 on miss
//   lut_hit_o     : lookup matched a valid entry
//   count_o       : number of valid entries
//   full_o        : count_o == DEPTH
//   busy_o        : sweep in progress
module prog_lut #(
   parameter int ADDR_W = 9,
   parameter int VAL_W  = 16,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   prog_lut_if.slave         wr,
   input  logic              clear_i,
   input  logic [ADDR_W-1:0] lut_address_i,
   output logic [VAL_W-1:0]  lut_val_o,
   output logic              lut_hit_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              full_o,
   output logic              busy_o
);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state_q;
   logic [DEPTH-1:0]  vld_q;
   logic [ADDR_W-1:0] key_q [DEPTH];
   logic [VAL_W-1:0]  val_q [DEPTH];
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q;

   logic              match;
   logic [IDX_W-1:0]  match_idx;
   logic [IDX_W-1:0]  free_idx;
   logic              accept;

   // Keys of valid entries are unique, so at most one entry can match and
   // OR-ing the targets is equivalent to a priority select.
   always_comb begin
      lut_hit_o = 1'b0;
      lut_val_o = '0;
      match     = 1'b0;
      match_idx = '0;
      free_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (key_q[i] == lut_address_i)) begin
            lut_hit_o = 1'b1;
            lut_val_o = lut_val_o | val_q[i];
         end
         if (vld_q[i] && (key_q[i] == wr.key)) begin
            match     = 1'b1;
            match_idx = IDX_W'(i);
         end
      end
      // Descending scan leaves the lowest-index free slot.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!vld_q[i]) free_idx = IDX_W'(i);
      end
   end

   assign full_o   = (cnt_q == CNT_W'(DEPTH));
   assign count_o  = cnt_q;
   assign busy_o   = (state_q == CLEAR);
   assign wr.ready = (state_q == IDLE) && !clear_i && (!full_o || match);
   assign accept   = wr.valid && wr.ready;

   // Entry payload carries no reset; only the valid bits define contents.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (match) begin
            val_q[match_idx] <= wr.val;
         end else begin
            key_q[free_idx] <= wr.key;
            val_q[free_idx] <= wr.val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vld_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clear_i) begin
                  state_q <= CLEAR;
                  idx_q   <= '0;
               end else if (accept && !match) begin
                  vld_q[free_idx] <= 1'b1;
                  cnt_q           <= cnt_q + CNT_W'(1);
               end
            end
            CLEAR: begin
               vld_q[idx_q] <= 1'b0;
               if (vld_q[idx_q]) cnt_q <= cnt_q - CNT_W'(1);
               idx_q <= idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(DEPTH - 1)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_prog_lut.sv
module tb_prog_lut;
   localparam int ADDR_W = 9;
   localparam int VAL_W  = 16;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              clear;
   logic [ADDR_W-1:0] lut_address;
   logic [VAL_W-1:0]  lut_val;
   logic              lut_hit;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              busy;

   prog_lut_if #(.ADDR_W(ADDR_W), .VAL_W(VAL_W)) wr_if ();

   prog_lut #(.ADDR_W(ADDR_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr            (wr_if.slave),
      .clear_i       (clear),
      .lut_address_i (lut_address),
      .lut_val_o     (lut_val),
      .lut_hit_o     (lut_hit),
      .count_o       (count),
      .full_o        (full),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned val;
      bit          hit;
      int unsigned cnt;
      bit          full;
      bit          busy;
      bit          ready;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: a slot table where new keys take the lowest free slot,
   // and a sweep pointer that walks the slots while clearing.
   bit          m_known = 0;
   bit          m_vld [DEPTH];
   int unsigned m_key [DEPTH];
   int unsigned m_val [DEPTH];
   bit          m_clearing;
   int          m_sweep;

   function automatic int find_key(input int unsigned k);
      for (int i = 0; i < DEPTH; i++)
         if (m_vld[i] && m_key[i] == k) return i;
      return -1;
   endfunction

   function automatic int entries();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (m_vld[i]) n++;
      return n;
   endfunction

   function automatic bit m_ready(input bit c, input int unsigned k);
      return !m_clearing && !c && (entries() < DEPTH || find_key(k) >= 0);
   endfunction

   task automatic step(input bit r, input bit v, input int unsigned k,
                       input int unsigned d, input bit c, input int unsigned a);
      exp_t e;
      int   idx;
      bit   rdy;
      rst          = r;
      wr_if.valid  = v;
      wr_if.key    = ADDR_W'(k);
      wr_if.val    = VAL_W'(d);
      clear        = c;
      lut_address  = ADDR_W'(a);
      rdy          = m_ready(c, k);
      if (m_known) begin
         idx     = find_key(a);
         e.hit   = (idx >= 0);
         e.val   = (idx >= 0) ? m_val[idx] : 0;
         e.cnt   = entries();
         e.full  = (entries() == DEPTH);
         e.busy  = m_clearing;
         e.ready = rdy;
         exp_q.push_back(e);
      end
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
         m_clearing = 0;
         m_sweep    = 0;
         m_known    = 1;
      end else if (m_known) begin
         if (m_clearing) begin
            m_vld[m_sweep] = 0;
            if (m_sweep == DEPTH - 1) m_clearing = 0;
            m_sweep = (m_sweep + 1) % DEPTH;
         end else if (c) begin
            m_clearing = 1;
            m_sweep    = 0;
         end else if (v && rdy) begin
            idx = find_key(k);
            if (idx >= 0) begin
               m_val[idx] = d;
            end else begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (!m_vld[i]) begin
                     m_vld[i] = 1; m_key[i] = k; m_val[i] = d;
                     break;
                  end
               end
            end
         end
      end
      #1;
   endtask

   task automatic idle(input int unsigned a);
      step(0, 0, 0, 0, 0, a);
   endtask

   task automatic wr(input int unsigned k, input int unsigned d, input int unsigned a);
      step(0, 1, k, d, 0, a);
   endtask

   // Monitor: the table presents its outputs every cycle; compare mid-cycle.
   task automatic chk(input string name, input int unsigned act, input int unsigned req);
      if (act != req) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("lut_val",  lut_val,     e.val);
            chk("lut_hit",  lut_hit,     e.hit);
            chk("count",    count,       e.cnt);
            chk("full",     full,        e.full);
            chk("busy",     busy,        e.busy);
            chk("wr_ready", wr_if.ready, e.ready);
         end
      end
   end

   initial begin
      int unsigned keys [$];
      int unsigned k, a;
      rst = 1; clear = 0; wr_if.valid = 0; wr_if.key = '0; wr_if.val = '0;
      lut_address = '0;
      #1;
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      idle(9'h01D);

      // Basic writes and lookups
      wr(9'h01D, 10, 9'h01D);
      wr(9'h01F, 33, 9'h01D);
      idle(9'h01D);
      idle(9'h01F);
      idle(9'h100);

      // Overwrite in place, same-cycle lookup sees old value
      wr(9'h021, 58, 9'h021);
      wr(9'h021, 10, 9'h021);
      idle(9'h021);

      // Fill, refuse a new key, accept an existing one
      for (int i = 0; i < DEPTH - 3; i++) wr(9'h040 + i, 100 + i, 9'h040 + i);
      for (int i = 0; i < 3; i++) wr(9'h1FF, 5, 9'h1FF);
      wr(9'h01D, 77, 9'h01D);
      idle(9'h01D);

      // clear with a simultaneous write, count = 3
      step(1, 0, 0, 0, 0, 0);
      wr(9'h001, 1, 0); wr(9'h002, 2, 0); wr(9'h003, 3, 0);
      step(0, 1, 9'h004, 4, 1, 9'h004);
      for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 9'h004, 4, 0, 9'h003);

      // key at index 5 survives the first 5 sweep cycles
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) wr(9'h080 + i, 200 + i, 0);
      step(0, 0, 0, 0, 1, 9'h085);
      for (int i = 0; i < DEPTH + 1; i++) idle(9'h085);

      // Reset mid-sweep with 10 valid entries
      for (int i = 0; i < 10; i++) wr(9'h0A0 + i, 300 + i, 0);
      step(0, 0, 0, 0, 1, 9'h0A0);
      for (int i = 0; i < 7; i++) idle(9'h0A9);
      step(1, 0, 0, 0, 0, 9'h0A9);
      idle(9'h0A9);
      wr(9'h0A9, 9, 9'h0A9);
      idle(9'h0A9);

      // Randomized traffic
      for (int n = 0; n < 10000; n++) begin
         k = $urandom_range(0, 40);
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 511);
         else a = $urandom_range(0, 40);
         step($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 6, k,
              $urandom_range(0, 65535), $urandom_range(0, 59) == 0, a);
      end

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
